// File: rtl/mem_wb_result_pipe.sv
// EX/MEM -> MEM/WB -> WB result pipe with a single-port data-memory access stage.
// It produces the forwarding sources, the register-file write port and the memory-wait stall.
module mem_wb_result_pipe #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_aluResult,
  input  logic [DATA_W-1:0] ex_pcNext,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic [ADDR_W-1:0] ex_regAddr,
  input  logic              ex_regWe,
  input  logic              ex_memToReg,
  input  logic              ex_memWrite,
  input  logic              ex_jal,
  input  logic              flush,
  output logic              ex_ready,
  output logic [ADDR_W-1:0] regAddr_EX_MEM,
  output logic [DATA_W-1:0] aluResult_EX_MEM,
  output logic [DATA_W-1:0] pcNext_EX_MEM,
  output logic              regWe_MEM,
  output logic              jal_EX_MEM,
  output logic              memToReg_EX_MEM,
  output logic [ADDR_W-1:0] regAddr_MEM_WB,
  output logic [DATA_W-1:0] aluResult_MEM_WB,
  output logic [DATA_W-1:0] pcNext_MEM_WB,
  output logic [DATA_W-1:0] memData_MEM_WB,
  output logic              regWe_MEM_WB,
  output logic              jal_MEM_WB,
  output logic              memToReg_MEM_WB,
  output logic [DATA_W-1:0] writeData_WB,
  output logic [ADDR_W-1:0] writeAddr_WB,
  output logic              writeEnable_WB,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_stall,
  output logic              mem_err
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StError} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;

  logic              valid_em_q, we_em_q, mtr_em_q, mw_em_q, jal_em_q;
  logic [ADDR_W-1:0] ra_em_q;
  logic [DATA_W-1:0] alu_em_q, pc_em_q, sd_em_q;

  logic              valid_mw_q, we_mw_q, mtr_mw_q, jal_mw_q;
  logic [ADDR_W-1:0] ra_mw_q;
  logic [DATA_W-1:0] alu_mw_q, pc_mw_q, md_mw_q;

  logic              wb_we_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic memop_em, frozen, advance;

  always_comb begin
    memop_em  = mtr_em_q | mw_em_q;
    frozen    = (state_q == StError);
    mem_req   = valid_em_q && memop_em && !frozen;
    mem_stall = mem_req && !mem_ready;
    ex_ready  = !mem_stall && !frozen;
    advance   = valid_em_q && !frozen && (!memop_em || mem_ready);
  end

  // Memory-wait FSM: cnt_q counts cycles spent waiting on the current request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_req && !mem_ready) begin
            state_q <= StBusy;
            cnt_q   <= CntW'(1);
          end
        end
        StBusy: begin
          if (mem_ready) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntW'(MEM_TIMEOUT)) begin
            state_q <= StError;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StError: state_q <= StError;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stores never write the register file, so their regWe is dropped on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_em_q <= 1'b0;
      we_em_q    <= 1'b0;
      mtr_em_q   <= 1'b0;
      mw_em_q    <= 1'b0;
      jal_em_q   <= 1'b0;
      ra_em_q    <= '0;
      alu_em_q   <= '0;
      pc_em_q    <= '0;
      sd_em_q    <= '0;
    end else if (ex_ready) begin
      valid_em_q <= ex_valid && !flush;
      we_em_q    <= ex_regWe && !ex_memWrite;
      mtr_em_q   <= ex_memToReg;
      mw_em_q    <= ex_memWrite;
      jal_em_q   <= ex_jal;
      ra_em_q    <= ex_regAddr;
      alu_em_q   <= ex_aluResult;
      pc_em_q    <= ex_pcNext;
      sd_em_q    <= ex_storeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mw_q <= 1'b0;
      we_mw_q    <= 1'b0;
      mtr_mw_q   <= 1'b0;
      jal_mw_q   <= 1'b0;
      ra_mw_q    <= '0;
      alu_mw_q   <= '0;
      pc_mw_q    <= '0;
      md_mw_q    <= '0;
    end else if (advance) begin
      valid_mw_q <= 1'b1;
      we_mw_q    <= we_em_q;
      mtr_mw_q   <= mtr_em_q;
      jal_mw_q   <= jal_em_q;
      ra_mw_q    <= ra_em_q;
      alu_mw_q   <= alu_em_q;
      pc_mw_q    <= pc_em_q;
      md_mw_q    <= mem_rdata;
    end else begin
      valid_mw_q <= 1'b0;
      we_mw_q    <= 1'b0;
    end
  end

  always_comb begin
    rf_we    = valid_mw_q && we_mw_q && (ra_mw_q != '0);
    rf_addr  = ra_mw_q;
    rf_wdata = jal_mw_q ? pc_mw_q : (mtr_mw_q ? md_mw_q : alu_mw_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= rf_we;
      wb_addr_q <= rf_addr;
      wb_data_q <= rf_wdata;
    end
  end

  assign regAddr_EX_MEM   = ra_em_q;
  assign aluResult_EX_MEM = alu_em_q;
  assign pcNext_EX_MEM    = pc_em_q;
  assign regWe_MEM        = valid_em_q && we_em_q;
  assign jal_EX_MEM       = jal_em_q;
  assign memToReg_EX_MEM  = mtr_em_q;

  assign regAddr_MEM_WB   = ra_mw_q;
  assign aluResult_MEM_WB = alu_mw_q;
  assign pcNext_MEM_WB    = pc_mw_q;
  assign memData_MEM_WB   = md_mw_q;
  assign regWe_MEM_WB     = valid_mw_q && we_mw_q;
  assign jal_MEM_WB       = jal_mw_q;
  assign memToReg_MEM_WB  = mtr_mw_q;

  assign writeData_WB     = wb_data_q;
  assign writeAddr_WB     = wb_addr_q;
  assign writeEnable_WB   = wb_we_q;

  assign mem_we           = mem_req && mw_em_q;
  assign mem_addr         = alu_em_q;
  assign mem_wdata        = sd_em_q;
  assign mem_err          = err_q;

endmodule

// File: doc/mem_wb_result_pipe.md
Name: mem_wb_result_pipe

Overview:
Producer side of the execute-stage forwarding path. It registers execute-stage results into the EX/MEM, MEM/WB and WB holding stages and runs the data-memory access for loads and stores. It drives every in-flight result, address and enable that the forwarding logic and the register file consume. It sits between the ALU and the register file and generates the memory-wait stall for the hazard unit.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 4, register address width (16 registers; R0 is hardwired zero)
MEM_TIMEOUT, 255, max wait cycles for mem_ready before mem_err

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction
ex_aluResult  in  16  ALU result / memory address
ex_pcNext  in  16  PC+2 (link value for jal)
ex_storeData  in  16  store data (already forwarded)
ex_regAddr  in  4  destination register
ex_regWe  in  1  instruction writes a register
ex_memToReg  in  1  load
ex_memWrite  in  1  store
ex_jal  in  1  link instruction
flush  in  1  kill the instruction presented on ex_*
ex_ready  out  1  EX/MEM accepts ex_* this cycle
regAddr_EX_MEM, aluResult_EX_MEM, pcNext_EX_MEM  out  4/16/16  EX/MEM contents
regWe_MEM, jal_EX_MEM, memToReg_EX_MEM  out  1 each  EX/MEM controls; regWe_MEM is gated by valid
regAddr_MEM_WB, aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB  out  4/16/16/16  MEM/WB contents
regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB  out  1 each  MEM/WB controls; regWe gated by valid
writeData_WB, writeAddr_WB, writeEnable_WB  out  16/4/1  WB-stage copy of the last committed write
rf_we, rf_addr, rf_wdata  out  1/4/16  register-file write port (from MEM/WB)
mem_req, mem_we  out  1 each  data-memory request and write
mem_addr, mem_wdata  out  16 each  address and store data
mem_rdata  in  16  load data, valid when mem_ready=1
mem_ready  in  1  memory completes the request this cycle
mem_stall  out  1  mem_req && !mem_ready
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): all stage valids=0; every data/address output=0; all enables, mem_req and mem_err=0; FSM=IDLE; wait counter=0. Reset mid-access abandons the access with no write.
- EX/MEM has a valid bit. When ex_ready=1 it loads ex_*, with valid = ex_valid && !flush. ex_ready = !mem_stall && state!=ERROR.
- mem_req = valid_EX_MEM && (memToReg_EX_MEM || memWrite_EX_MEM) && state!=ERROR. mem_we = mem_req && memWrite_EX_MEM. mem_addr = aluResult_EX_MEM. mem_wdata = registered storeData.
- Zero-wait: when mem_ready=1 in the request cycle, there is no stall and the instruction advances at the next edge.
- FSM:
  - IDLE -> BUSY when mem_req && !mem_ready (counter=1).
  - BUSY: counter increments each cycle. It returns to IDLE on mem_ready. It moves to ERROR when counter==MEM_TIMEOUT and mem_ready=0.
  - ERROR: mem_err=1; the pipe is frozen until reset.
- MEM/WB load, each edge:
  - When EX/MEM advances (valid && (!memop || mem_ready)): it copies EX/MEM; memData_MEM_WB = mem_rdata sampled that edge.
  - Else: it loads a bubble (valid=0, regWe_MEM_WB=0; other fields hold).
- Register-file write:
  - rf_we = valid_MEM_WB && regWe_MEM_WB && regAddr_MEM_WB!=0.
  - rf_wdata = jal ? pcNext : memToReg ? memData : aluResult.
  - rf_addr = regAddr_MEM_WB.
- WB stage: each edge it registers rf_we/rf_addr/rf_wdata into writeEnable_WB/writeAddr_WB/writeData_WB. This gives exactly 1 cycle of retention after the register-file write.
- Stores: regWe ignored, never write the register file. jal with memop is illegal and is not checked.
- Simultaneous flush and stall: flush is ignored while ex_ready=0. The hazard unit re-presents the flush.
- Latency: ALU result to rf_we is 2 edges with zero-wait memory. Each wait cycle adds 1 edge.

Test Plan:
- ALU add R3=0x1234 at cycle 0, mem idle -> regWe_MEM=1/regAddr_EX_MEM=3 at cycle 1; rf_we=1, rf_addr=3, rf_wdata=0x1234 at cycle 2; writeEnable_WB=1, writeData_WB=0x1234 at cycle 3.
- Load R5 from 0x0040, mem_ready low for 3 cycles then high with rdata 0xBEEF -> mem_stall=1 for 3 cycles, ex_ready=0, MEM/WB bubbles (regWe_MEM_WB=0); then memData_MEM_WB=0xBEEF, rf_wdata=0xBEEF, rf_addr=5.
- jal R15, pcNext=0x0102 -> rf_wdata=0x0102, not aluResult; write to R0 -> rf_we=0.
- Store 0x00AA to 0x0010 with regWe=1 -> mem_we=1, mem_wdata=0x00AA, rf_we=0.
- flush with ex_valid=1 -> regWe_MEM stays 0 and no mem_req; mem_ready held 0 for MEM_TIMEOUT cycles -> mem_err=1, ex_ready=0 until rst_n.
- rst_n pulsed low during BUSY -> all outputs 0 immediately (async), no rf_we afterwards.
